// File: rtl/fact_host_ctrl.sv
// rtl/fact_host_ctrl.sv - host-side controller that issues one factorial request at a time
//
// Accepts an operand on a valid/ready request port, starts the factorial unit
// with a one-cycle go pulse, waits for a done/error strobe or a timeout, then
// holds a response until the consumer takes it.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   req_valid/ready request handshake, req_n = 4-bit operand
//   fact_go, fact_n start pulse and held operand to the factorial unit
//   fact_done/error completion/error strobes, fact_result valid with fact_done
//   rsp_valid/ready response handshake
//   rsp_result      captured result (0 on error or timeout)
//   rsp_error       response reports an operand error
//   rsp_timeout     response reports a timeout
//   busy            high whenever not idle
//   req_count       saturating count of accepted requests
//   fail_count      saturating count of error/timeout responses
module fact_host_ctrl #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_n,
  output logic        fact_go,
  output logic [3:0]  fact_n,
  input  logic        fact_done,
  input  logic        fact_error,
  input  logic [31:0] fact_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_error,
  output logic        rsp_timeout,
  output logic        busy,
  output logic [7:0]  req_count,
  output logic [7:0]  fail_count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  // Last timer value spent in WAIT before the request is abandoned.
  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

  logic [1:0]  state;
  logic [15:0] timer;

  // Status outputs decode straight from the state register, so reset
  // forcing IDLE immediately yields req_ready=1 and everything else 0.
  assign req_ready = (state == S_IDLE);
  assign fact_go   = (state == S_ISSUE);
  assign rsp_valid = (state == S_RESP);
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      timer       <= '0;
      fact_n      <= '0;
      rsp_result  <= '0;
      rsp_error   <= 1'b0;
      rsp_timeout <= 1'b0;
      req_count   <= '0;
      fail_count  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            fact_n <= req_n;
            if (req_count != 8'hFF) req_count <= req_count + 8'd1;
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          timer <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          // Error outranks done when both strobes land together.
          if (fact_error) begin
            rsp_result  <= '0;
            rsp_error   <= 1'b1;
            rsp_timeout <= 1'b0;
            if (fail_count != 8'hFF) fail_count <= fail_count + 8'd1;
            state <= S_RESP;
          end else if (fact_done) begin
            rsp_result  <= fact_result;
            rsp_error   <= 1'b0;
            rsp_timeout <= 1'b0;
            state <= S_RESP;
          end else if (timer == TIMER_LAST) begin
            rsp_result  <= '0;
            rsp_error   <= 1'b0;
            rsp_timeout <= 1'b1;
            if (fail_count != 8'hFF) fail_count <= fail_count + 8'd1;
            state <= S_RESP;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        S_RESP: begin
          // rsp_* registers are left alone on exit so they hold until the
          // next capture.
          if (rsp_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fact_host_ctrl.sv
// tb/tb_fact_host_ctrl.sv - scoreboard bench for fact_host_ctrl
module tb_fact_host_ctrl;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_n = '0;
  logic        fact_go;
  logic [3:0]  fact_n;
  logic        fact_done = 1'b0;
  logic        fact_error = 1'b0;
  logic [31:0] fact_result = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_result;
  logic        rsp_error;
  logic        rsp_timeout;
  logic        busy;
  logic [7:0]  req_count;
  logic [7:0]  fail_count;

  fact_host_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_n(req_n),
    .fact_go(fact_go), .fact_n(fact_n),
    .fact_done(fact_done), .fact_error(fact_error), .fact_result(fact_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_error(rsp_error), .rsp_timeout(rsp_timeout),
    .busy(busy), .req_count(req_count), .fail_count(fail_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  typedef struct {
    logic [31:0] result;
    logic        err;
    logic        tmo;
    int          edge_no;
    logic [7:0]  rc;
    logic [7:0]  fc;
  } exp_t;

  exp_t exp_q[$];
  int   exp_req = 0;
  int   exp_fail = 0;
  bit   stim_done = 0;

  function automatic logic [31:0] factorial(input int n);
    logic [31:0] r = 32'd1;
    for (int i = 2; i <= n; i++) r = r * i;
    return r;
  endfunction

  task automatic wait_idle();
    int k = 0;
    @(negedge clk);
    while (!req_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!req_ready) chk("idle_wait", 32'(req_ready), 32'd1);
  endtask

  // kind: 0 no strobe, 1 done, 2 error, 3 done+error together.
  // d: WAIT-cycle index (timer value) at which the strobe is presented.
  task automatic do_txn(input logic [3:0] n, input int kind, input int d);
    exp_t e;
    int   e_a;
    bit   strobe_in_time;
    wait_idle();
    req_valid = 1'b1;
    req_n = n;
    @(posedge clk);
    #1 req_n = ~n;  // req_valid stays high in ISSUE; must be ignored
    @(negedge clk);
    e_a = cyc;
    exp_req = (exp_req < 255) ? exp_req + 1 : 255;
    chk("fact_go", 32'(fact_go), 32'd1);
    chk("fact_n", 32'(fact_n), 32'(n));
    chk("req_count_acc", 32'(req_count), 32'(exp_req));
    strobe_in_time = (kind != 0) && (d < TO);
    if (strobe_in_time && kind == 1) begin
      e.result = factorial(int'(n)); e.err = 1'b0; e.tmo = 1'b0;
      e.edge_no = e_a + 2 + d;
    end else if (strobe_in_time) begin
      e.result = '0; e.err = 1'b1; e.tmo = 1'b0;
      e.edge_no = e_a + 2 + d;
    end else begin
      e.result = '0; e.err = 1'b0; e.tmo = 1'b1;
      e.edge_no = e_a + 1 + TO;
    end
    if (e.err || e.tmo) exp_fail = (exp_fail < 255) ? exp_fail + 1 : 255;
    e.rc = 8'(exp_req);
    e.fc = 8'(exp_fail);
    exp_q.push_back(e);
    @(posedge clk);
    #1 req_valid = 1'b0;
    if (kind != 0) begin
      repeat (d) @(posedge clk);
      #1;
      fact_done   = (kind == 1 || kind == 3);
      fact_error  = (kind == 2 || kind == 3);
      fact_result = (kind == 2) ? $urandom : factorial(int'(n));
      @(posedge clk);
      #1;
      fact_done = 1'b0;
      fact_error = 1'b0;
      fact_result = $urandom;
    end
    wait_idle();
  endtask

  // Monitor: pops the scoreboard whenever a response appears and applies
  // random back-pressure while checking the response holds steady.
  initial begin : monitor
    exp_t e;
    logic [31:0] c_res;
    logic c_err, c_tmo;
    int hold;
    forever begin
      @(negedge clk);
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
          rsp_ready = 1'b1;
          @(negedge clk);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_result", rsp_result, e.result);
          chk("rsp_error", 32'(rsp_error), 32'(e.err));
          chk("rsp_timeout", 32'(rsp_timeout), 32'(e.tmo));
          chk("rsp_latency", 32'(cyc), 32'(e.edge_no));
          chk("req_count", 32'(req_count), 32'(e.rc));
          chk("fail_count", 32'(fail_count), 32'(e.fc));
          c_res = rsp_result; c_err = rsp_error; c_tmo = rsp_timeout;
          rsp_ready = 1'b0;
          hold = $urandom_range(0, 5);
          for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_stable", {rsp_result ^ c_res, 29'd0, rsp_error ^ c_err, rsp_timeout ^ c_tmo} == '0 ? 32'd1 : 32'd0, 32'd1);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
          end
          rsp_ready = 1'b1;
          @(negedge clk);
          chk("rsp_fall", 32'(rsp_valid), 32'd0);
          chk("rsp_hold", (rsp_result == c_res && rsp_error == c_err && rsp_timeout == c_tmo) ? 32'd1 : 32'd0, 32'd1);
          chk("ready_after", 32'(req_ready), 32'd1);
        end
        rsp_ready = 1'(($urandom & 1));
      end else begin
        rsp_ready = 1'(($urandom & 1));
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int kind, d;
    logic [3:0] n;
    // Reset state
    #7;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_outputs", {rsp_result, 14'd0, fact_n, fact_go, rsp_valid, rsp_error, rsp_timeout, busy, req_count, fail_count} == '0 ? 32'd1 : 32'd0, 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // Reset in the middle of WAIT abandons the request.
    wait_idle();
    req_valid = 1'b1;
    req_n = 4'd7;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_req_ready", 32'(req_ready), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_go", 32'(fact_go), 32'd0);
    chk("midrst_req_count", 32'(req_count), 32'd0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3 * TO; i++) begin
      @(negedge clk);
      chk("midrst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    exp_req = 0;
    exp_fail = 0;

    // Directed cases
    do_txn(4'd5, 1, 1);       // nominal, 120
    do_txn(4'd13, 2, 0);      // operand error
    do_txn(4'd3, 1, TO + 2);  // timeout, late done ignored
    do_txn(4'd4, 3, 2);       // collision -> error
    do_txn(4'd0, 1, 0);       // earliest response
    do_txn(4'd12, 1, TO - 1); // strobe on the final WAIT cycle
    do_txn(4'd9, 0, 0);       // plain timeout

    // Random traffic, long enough to saturate req_count
    for (int t = 0; t < 300; t++) begin
      n = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) kind = 0;
      else if (n > 12) kind = 2;
      else kind = ($urandom_range(0, 7) == 0) ? 3 : 1;
      d = ($urandom_range(0, 5) == 0) ? $urandom_range(TO, TO + 3) : $urandom_range(0, TO - 1);
      do_txn(n, kind, d);
    end
    repeat (10) @(negedge clk);
    chk("req_count_sat", 32'(req_count), 32'd255);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    stim_done = 1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
